// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x XLEN integer register file with a per-register pending-write
//   scoreboard. Decode reads rs1/rs2 combinationally and registers an
//   in-flight rd when an issue is accepted. The writeback stage retires it.
//   A source operand with an outstanding write stalls issue.
// Ports
//   clk_i, rst_i                          clock, synchronous active-high reset
//   rs1_addr_i/rs2_addr_i -> rsN_data_o   combinational reads, write-first bypass
//   issue_valid_i, issue_uses_rs1_i/rs2_i,
//   issue_regwrite_i, issue_rd_i          issue request from decode
//   issue_ready_o                         hazard-free / no counter overflow
//   regwrite_i, rd_addr_i, wb_data_i      writeback (retire) port
//   flush_i                               discard all pending writes

module regfile_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Saturation is enforced upstream: inc is blocked at max, dec only when nonzero.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i)     r_cnt <= '0;
    else if (i_inc && !i_dec) r_cnt <= r_cnt + CNT_W'(1);
    else if (i_dec && !i_inc) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            issue_valid_i,
  input  logic            issue_uses_rs1_i,
  input  logic            issue_uses_rs2_i,
  input  logic            issue_regwrite_i,
  input  logic [4:0]      issue_rd_i,
  output logic            issue_ready_o,
  input  logic            regwrite_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREG-1:0][XLEN-1:0]  r_regs;
  logic [NREG-1:0][CNT_W-1:0] w_cnt;
  logic [NREG-1:0]            w_retire, w_pend, w_inc, w_dec;
  logic                       w_full, w_accept;

  // x0 is never tracked and never pending.
  assign w_cnt[0]    = '0;
  assign w_retire[0] = 1'b0;
  assign w_pend[0]   = 1'b0;
  assign w_inc[0]    = 1'b0;
  assign w_dec[0]    = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    assign w_retire[g] = regwrite_i && (rd_addr_i == 5'(g));
    // Last outstanding write retiring now is covered by the bypass, so not a hazard.
    assign w_pend[g]   = (w_cnt[g] != '0) && !((w_cnt[g] == CNT_ONE) && w_retire[g]);
    assign w_inc[g]    = w_accept && issue_regwrite_i && (issue_rd_i == 5'(g));
    // Untracked retires (count already 0) write data but leave the count alone.
    assign w_dec[g]    = w_retire[g] && (w_cnt[g] != '0);

    regfile_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .i_inc   (w_inc[g]),
      .i_dec   (w_dec[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  // A retire of the same rd this cycle frees one slot, so a full counter may still accept.
  assign w_full = issue_regwrite_i && (issue_rd_i != 5'd0) &&
                  (w_cnt[issue_rd_i] == CNT_MAX) && !w_retire[issue_rd_i];

  assign issue_ready_o = !(issue_uses_rs1_i && w_pend[rs1_addr_i]) &&
                         !(issue_uses_rs2_i && w_pend[rs2_addr_i]) && !w_full;

  // Issues during a flush are dropped, so they never reach the counters.
  assign w_accept = issue_valid_i && issue_ready_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                r_regs <= '0;
    else if (regwrite_i && rd_addr_i != 5'd0) r_regs[rd_addr_i] <= wb_data_i;
  end

  always_comb begin
    rs1_data_o = r_regs[rs1_addr_i];
    if (rs1_addr_i == 5'd0)                              rs1_data_o = '0;
    else if (regwrite_i && rd_addr_i == rs1_addr_i)      rs1_data_o = wb_data_i;
    rs2_data_o = r_regs[rs2_addr_i];
    if (rs2_addr_i == 5'd0)                              rs2_data_o = '0;
    else if (regwrite_i && rd_addr_i == rs2_addr_i)      rs2_data_o = wb_data_i;
  end
endmodule
